// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants for the 4-digit multiplexed seven-segment scanner:
// active-low segment patterns, digit count and the per-slot FSM encoding.
package seg7_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_e;

endpackage

// File: rtl/seg7_scan_ctrl_decode.sv
// Combinational BCD-to-seven-segment decode; codes 10..15 show nothing.
module seg7_decode
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with blanking guard band,
// double-buffered display value (frame-aligned update) and leading-zero blanking.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 25000,
  parameter int BLANK_CYC = 500
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LD,
  input  logic [15:0] DIN,
  input  logic        LZB,
  output logic [6:0]  SEG,
  output logic [3:0]  K,
  output logic        PEND,
  output logic        FRAME
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  generate
    if (TICK_DIV < 2 || BLANK_CYC <= 0 || BLANK_CYC >= TICK_DIV) begin : g_bad_params
      $error("seg7_scan_ctrl: need TICK_DIV >= 2 and 0 < BLANK_CYC < TICK_DIV");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  slot_state_e   state_q, state_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pend_q, pend_d;
  logic          frame_q, frame_d;
  logic          wrap, xfer;

  always_comb begin
    wrap     = (cnt_q == CNT_LAST);
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    dig_d    = wrap ? dig_q + 2'd1 : dig_q;
    // Transfer only at the very end of digit 3 so a frame never mixes values.
    xfer     = wrap && (dig_q == 2'd3) && pend_q;
    disp_d   = xfer ? shadow_q : disp_q;
    shadow_d = LD ? DIN : shadow_q;
    pend_d   = LD | (pend_q & ~xfer);
    state_d  = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
    frame_d  = (cnt_d == '0) && (dig_d == 2'd0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      dig_q    <= 2'd0;
      state_q  <= ST_BLANK;
      disp_q   <= 16'h0000;
      shadow_q <= 16'h0000;
      pend_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      state_q  <= state_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      frame_q  <= frame_d;
    end
  end

  logic [3:0] nibble;
  logic [6:0] dec_seg;
  logic       lz_blank;

  always_comb begin
    nibble = disp_q[{dig_q, 2'b00} +: 4];
    // A digit is a leading zero when it and every digit to its left are zero.
    case (dig_q)
      2'd3:    lz_blank = (disp_q[15:12] == 4'h0);
      2'd2:    lz_blank = (disp_q[15:8]  == 8'h00);
      2'd1:    lz_blank = (disp_q[15:4]  == 12'h000);
      default: lz_blank = 1'b0;
    endcase
    lz_blank = lz_blank & LZB;
  end

  seg7_decode u_decode (
    .bcd (nibble),
    .seg (dec_seg)
  );

  always_comb begin
    if (state_q == ST_BLANK) begin
      K   = 4'b1111;
      SEG = SEG_OFF;
    end else begin
      K   = ~(NUM_DIGITS'(1) << dig_q);
      SEG = lz_blank ? SEG_OFF : dec_seg;
    end
  end

  assign PEND  = pend_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random loads, every cycle
// compared against a position-based reference model of the display.
module tb_seg7_scan_ctrl;

  localparam int TD = 8;
  localparam int BC = 2;
  localparam int FRAME_LEN = 4 * TD;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LD  = 1'b0;
  logic [15:0] DIN = 16'h0000;
  logic        LZB = 1'b0;
  logic [6:0]  SEG;
  logic [3:0]  K;
  logic        PEND;
  logic        FRAME;

  seg7_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .LD    (LD),
    .DIN   (DIN),
    .LZB   (LZB),
    .SEG   (SEG),
    .K     (K),
    .PEND  (PEND),
    .FRAME (FRAME)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: m_t is the scan position (cycles since reset release).
  int          m_t = 0;
  logic [15:0] m_disp = 16'h0000;
  logic [15:0] m_shadow = 16'h0000;
  logic        m_pend = 1'b0;

  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [3:0] exp_k(int pos);
    int c = pos % TD;
    int d = (pos / TD) % 4;
    logic [3:0] k = 4'b1111;
    if (c >= BC) k[d] = 1'b0;
    return k;
  endfunction

  function automatic logic [6:0] exp_seg(int pos, logic [15:0] disp, logic lzb);
    int c = pos % TD;
    int d = (pos / TD) % 4;
    int dig = (int'(disp) >> (4 * d)) & 15;
    int upper = int'(disp) >> (4 * d);
    if (c < BC) return 7'h7F;
    if (lzb && d > 0 && upper == 0) return 7'h7F;
    if (dig > 9) return 7'h7F;
    return pat[dig];
  endfunction

  task automatic check_outputs();
    logic [3:0] ek;
    logic [6:0] es;
    logic       ef;
    ek = exp_k(m_t);
    es = exp_seg(m_t, m_disp, LZB);
    ef = (m_t > 0) && (m_t % FRAME_LEN == 0);
    n_checks++;
    assert (K === ek) else begin
      n_errors++;
      $error("FAIL k pos=%0d got=%b exp=%b", m_t, K, ek);
    end
    n_checks++;
    assert (SEG === es) else begin
      n_errors++;
      $error("FAIL seg pos=%0d got=%h exp=%h", m_t, SEG, es);
    end
    n_checks++;
    assert (PEND === m_pend) else begin
      n_errors++;
      $error("FAIL pend pos=%0d got=%b exp=%b", m_t, PEND, m_pend);
    end
    n_checks++;
    assert (FRAME === ef) else begin
      n_errors++;
      $error("FAIL frame pos=%0d got=%b exp=%b", m_t, FRAME, ef);
    end
  endtask

  task automatic cycle(input logic ld, input logic [15:0] din, input logic rst);
    logic xfer;
    LD  = ld;
    DIN = din;
    RST = rst;
    @(posedge CLK);
    if (rst) begin
      m_t = 0; m_disp = 16'h0000; m_shadow = 16'h0000; m_pend = 1'b0;
    end else begin
      xfer = (m_t % FRAME_LEN == FRAME_LEN - 1) && m_pend;
      if (xfer) m_disp = m_shadow;
      if (ld) begin
        m_shadow = din;
        m_pend = 1'b1;
      end else if (xfer) begin
        m_pend = 1'b0;
      end
      m_t++;
    end
    #1;
    check_outputs();
    LD = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 1'b0);
  endtask

  // Advance until the next edge is the one taken at frame position p.
  task automatic wait_pos(input int p);
    for (int i = 0; i < 2 * FRAME_LEN && (m_t % FRAME_LEN) != p; i++)
      cycle(1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    // Scenario 1: reset then idle, showing 0000.
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 16'hFFFF, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);
    idle(70);

    // Scenario 2: load 1234 during slot 1.
    wait_pos(TD + 3);
    cycle(1'b1, 16'h1234, 1'b0);
    idle(70);

    // Scenario 3: leading-zero blanking.
    LZB = 1'b1;
    cycle(1'b1, 16'h0050, 1'b0);
    idle(70);
    cycle(1'b1, 16'h0000, 1'b0);
    idle(70);

    // Scenario 4: invalid BCD digit.
    LZB = 1'b0;
    cycle(1'b1, 16'h00A9, 1'b0);
    idle(70);

    // Scenario 5: load in the transfer cycle while a value is pending.
    wait_pos(5);
    cycle(1'b1, 16'h1234, 1'b0);
    wait_pos(FRAME_LEN - 1);
    cycle(1'b1, 16'h5678, 1'b0);
    idle(70);

    // Scenario 6: one-cycle reset at cnt=5, d=2 with data pending.
    wait_pos(0);
    cycle(1'b1, 16'h9876, 1'b0);
    wait_pos(2 * TD + 5);
    cycle(1'b0, 16'h0000, 1'b1);
    idle(70);

    // Random loads, digits and blanking mode.
    for (int i = 0; i < 700; i++) begin
      if (i % 40 == 0) LZB = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        cycle(1'b1, 16'($urandom), 1'b0);
      else if ($urandom_range(0, 2) == 0)
        cycle(1'b1, {4'h0, 4'($urandom_range(0, 1)), 8'($urandom)}, 1'b0);
      else
        cycle(1'b0, 16'($urandom), 1'b0);
      if (i == 500) cycle(1'b0, 16'h0000, 1'b1);
    end
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
